// File: rtl/spi_master_cfg.sv
// SPI master, modes 0-3, MSB/LSB first, programmable half-period, NUM_CS active-low selects.
// Done pulse 1+(2*DATA_W+2)*(clk_div+1) cycles after start; start is ignored (not queued) while busy.
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 4,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_lsb_first,
    input  logic [DIV_W-1:0]  i_clk_div,
    input  logic [CS_W-1:0]   i_cs_sel,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic [NUM_CS-1:0] o_cs_n,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_tx_done
);

    localparam int EW = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [EW-1:0]       r_edge;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic                r_cpha;
    logic                r_lsb;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_CS-1:0]   r_cs_n;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_tx_done;

    logic                w_half_end;
    logic                w_last_edge;
    logic                w_leading;
    logic                w_drive;
    logic                w_sample;
    logic                w_tx_bit;
    logic [DATA_W-1:0]   w_tx_next;
    logic [DATA_W-1:0]   w_rx_next;
    logic [NUM_CS-1:0]   w_cs_dec;

    assign w_half_end  = (r_cnt == r_div);
    assign w_last_edge = (r_edge == EW'(2 * DATA_W - 1));
    assign w_leading   = ~r_edge[0];
    assign w_tx_bit    = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
    assign w_tx_next   = r_lsb ? (r_tx >> 1) : (r_tx << 1);
    assign w_rx_next   = r_lsb ? {i_miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], i_miso};

    // cpha=0 drives on trailing edges (the first bit went out at SETUP entry); cpha=1 on leading
    assign w_drive  = (r_state == S_SHIFT) && w_half_end &&
                      (r_cpha ? w_leading : (!w_leading && !w_last_edge));
    assign w_sample = (r_state == S_SHIFT) && w_half_end &&
                      (r_cpha ? !w_leading : w_leading);

    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (CS_W'(i) == i_cs_sel) w_cs_dec[i] = 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_SETUP;
            S_SETUP: if (w_half_end) w_next = S_SHIFT;
            S_SHIFT: if (w_half_end && w_last_edge) w_next = S_HOLD;
            S_HOLD:  if (w_half_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_edge     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_done  <= 1'b0;
            if (r_state == S_IDLE) begin
                if (i_start) begin
                    r_cnt  <= '0;
                    r_div  <= i_clk_div;
                    r_edge <= '0;
                    r_rx   <= '0;
                    r_cpha <= i_cpha;
                    r_lsb  <= i_lsb_first;
                    r_sclk <= i_cpol;
                    r_cs_n <= w_cs_dec;
                    if (i_cpha) begin
                        r_tx <= i_tx_data;
                    end else begin
                        r_mosi <= i_lsb_first ? i_tx_data[0] : i_tx_data[DATA_W-1];
                        r_tx   <= i_lsb_first ? (i_tx_data >> 1) : (i_tx_data << 1);
                    end
                end
            end else begin
                r_cnt <= w_half_end ? '0 : r_cnt + 1'b1;
            end
            if ((r_state == S_SHIFT) && w_half_end) begin
                r_sclk <= ~r_sclk;
                r_edge <= r_edge + 1'b1;
            end
            if (w_drive) begin
                r_mosi <= w_tx_bit;
                r_tx   <= w_tx_next;
            end
            if (w_sample) r_rx <= w_rx_next;
            if ((r_state == S_HOLD) && w_half_end) begin
                r_cs_n     <= '1;
                r_rx_data  <= r_rx;
                r_rx_valid <= 1'b1;
                r_tx_done  <= 1'b1;
            end
        end
    end

    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;
    assign o_cs_n     = r_cs_n;
    assign o_busy     = (r_state != S_IDLE);
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_tx_done  = r_tx_done;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg (DATA_W=8, DIV_W=8, NUM_CS=4) with a behavioural SPI slave.
module tb_spi_master_cfg;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       cpol, cpha, lsb_first;
    logic [7:0] clk_div;
    logic [1:0] cs_sel;
    logic       miso;
    logic       sclk, mosi, busy, rx_valid, tx_done;
    logic [3:0] cs_n;
    logic [7:0] rx_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int bad;
    int d0;

    always #5 clk = ~clk;

    spi_master_cfg #(.DATA_W(8), .DIV_W(8), .NUM_CS(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_tx_data(tx_data),
        .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb_first), .i_clk_div(clk_div),
        .i_cs_sel(cs_sel), .i_miso(miso), .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n),
        .o_busy(busy), .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_tx_done(tx_done)
    );

    // Slave model: loopback or a word returned in the configured mode
    logic       loop = 1'b1;
    logic       s_miso = 1'b0;
    logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
    logic       s_first = 1'b0;
    logic       sel_d = 1'b0;
    int         s_n = 0, s_nrx = 0, s_leads = 0;
    longint     s_last_lead = 0, s_period = 0;
    wire        sel = ~&cs_n;

    assign miso = loop ? mosi : s_miso;

    always @(negedge clk) sel_d <= sel;
    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    task automatic slave_drive();
        if (s_n < 8) begin
            s_miso = s_tx[s_lsb ? s_n : 7 - s_n];
            s_n++;
        end
    endtask

    task automatic slave_sample();
        if (s_nrx == 0) s_first = mosi;
        s_rx = s_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
        s_nrx++;
    endtask

    always @(posedge sel) begin
        s_n = 0; s_nrx = 0; s_rx = 8'h00; s_leads = 0;
        if (!s_cpha) slave_drive();
    end

    always @(sclk) begin
        if (sel_d) begin
            if (sclk != s_cpol) begin
                if (s_leads > 0) s_period = $time - s_last_lead;
                s_last_lead = $time;
                s_leads++;
                if (s_cpha) slave_drive(); else slave_sample();
            end else begin
                if (s_cpha) slave_sample(); else slave_drive();
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Caller is at a negedge; the following posedge samples start (cycle 1 afterwards)
    task automatic start_xfer(input logic [7:0] tx, input logic pol, input logic pha,
                              input logic lsb, input logic [7:0] div, input logic [1:0] cs,
                              input logic lp, input logic [7:0] stx);
        s_cpol = pol; s_cpha = pha; s_lsb = lsb; s_tx = stx; loop = lp;
        tx_data = tx; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div; cs_sel = cs;
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input logic [3:0] exp_cs, output int nbad);
        nbad = 0;
        while (tx_done !== 1'b1 && cyc < 3000) begin
            if (busy === 1'b1 && cs_n !== exp_cs) nbad++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tx_data = 8'h00; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; clk_div = 8'h00; cs_sel = 2'd0;
        repeat (3) step();
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_busy", busy, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_done", tx_done, 0);
        reset = 1'b0;
        step();

        // Mode 0 loopback, H=1: done at 1+18*1 = 19
        start_xfer(8'hA5, 0, 0, 0, 8'd0, 2'd0, 1, 8'h00);
        chk("m0_busy", busy, 1);
        wait_done(4'b1110, bad);
        chk("m0_cycle", cyc, 19);
        chk("m0_rx_data", rx_data, 8'hA5);
        chk("m0_rx_valid", rx_valid, 1);
        chk("m0_busy_done", busy, 0);
        chk("m0_pulses", s_leads, 8);
        chk("m0_slave_rx", s_rx, 8'hA5);
        step();
        chk("m0_done_low", tx_done, 0);
        chk("m0_valid_low", rx_valid, 0);
        chk("m0_rx_held", rx_data, 8'hA5);
        chk("m0_cs_idle", cs_n, 4'hF);

        // Mode 3, H=4: sclk period 80, done at 1+18*4 = 73
        start_xfer(8'h96, 1, 1, 0, 8'd3, 2'd1, 0, 8'h3C);
        chk("m3_sclk_idle", sclk, 1);
        wait_done(4'b1101, bad);
        chk("m3_cycle", cyc, 73);
        chk("m3_rx_data", rx_data, 8'h3C);
        chk("m3_slave_rx", s_rx, 8'h96);
        chk("m3_period", 32'(s_period), 80);
        chk("m3_cs_bad", bad, 0);
        step();
        chk("m3_sclk_after", sclk, 1);

        // Mode 1 LSB-first, H=2: done at 37
        start_xfer(8'h01, 0, 1, 1, 8'd1, 2'd0, 0, 8'h80);
        wait_done(4'b1110, bad);
        chk("m1_cycle", cyc, 37);
        chk("m1_first_bit", s_first, 1);
        chk("m1_slave_rx", s_rx, 8'h01);
        chk("m1_rx_data", rx_data, 8'h80);
        step();

        // Mode 2 LSB-first, H=1
        start_xfer(8'h01, 1, 0, 1, 8'd0, 2'd0, 0, 8'h4D);
        wait_done(4'b1110, bad);
        chk("m2_cycle", cyc, 19);
        chk("m2_first_bit", s_first, 1);
        chk("m2_slave_rx", s_rx, 8'h01);
        chk("m2_rx_data", rx_data, 8'h4D);
        step();

        // Chip select 2 only, held low from SETUP through HOLD
        start_xfer(8'h5A, 0, 0, 0, 8'd0, 2'd2, 1, 8'h00);
        chk("cs2_setup", cs_n, 4'b1011);
        wait_done(4'b1011, bad);
        chk("cs2_bad_cycles", bad, 0);
        chk("cs2_after", cs_n, 4'hF);
        chk("cs2_rx_data", rx_data, 8'h5A);
        step();

        // Second start during a transfer is dropped
        d0 = done_cnt;
        start_xfer(8'h12, 0, 0, 0, 8'd0, 2'd0, 1, 8'h00);
        while (cyc < 4) step();
        tx_data = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(4'b1110, bad);
        chk("ign_cycle", cyc, 19);
        chk("ign_rx_data", rx_data, 8'h12);
        chk("ign_slave_rx", s_rx, 8'h12);
        step(); step();
        chk("ign_done_count", done_cnt - d0, 1);
        chk("ign_not_queued", busy, 0);

        // Reset at cycle 10 of a mode 2 transfer (sclk would otherwise be 1)
        d0 = done_cnt;
        start_xfer(8'h77, 1, 0, 0, 8'd0, 2'd0, 1, 8'h00);
        while (cyc < 9) step();
        chk("rst10_busy_before", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst10_cs_n", cs_n, 4'hF);
        chk("rst10_sclk", sclk, 0);
        chk("rst10_busy", busy, 0);
        chk("rst10_tx_done", tx_done, 0);
        repeat (25) step();
        chk("rst10_no_done", done_cnt - d0, 0);

        // Normal transfer after reset, then a start in the done cycle itself
        start_xfer(8'hC3, 0, 0, 0, 8'd0, 2'd3, 1, 8'h00);
        wait_done(4'b0111, bad);
        chk("post_cycle", cyc, 19);
        chk("post_rx_data", rx_data, 8'hC3);
        start_xfer(8'h3A, 0, 0, 0, 8'd0, 2'd3, 1, 8'h00);
        chk("b2b_busy", busy, 1);
        wait_done(4'b0111, bad);
        chk("b2b_cycle", cyc, 19);
        chk("b2b_rx_data", rx_data, 8'h3A);
        chk("b2b_cs_bad", bad, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
